// File: rtl/proc_control.sv
// Instruction-sequencing control unit: latches an instruction in T0, then steps T1..T3 strobes.
// Optional mvnz (op 100) is enabled by defining PROC_CTRL_MVNZ_EN.
module proc_control #(
    parameter int DATA_WIDTH = 16,
    parameter int REG_SEL_W  = 3
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      run,
    input  logic [DATA_WIDTH-1:0]     din,
    input  logic                      g_zero,
    output logic                      irin,
    output logic [2**REG_SEL_W-1:0]   rin,
    output logic [2**REG_SEL_W-1:0]   rout,
    output logic                      gout,
    output logic                      dinout,
    output logic                      ain,
    output logic                      gin,
    output logic                      sub,
    output logic                      done,
    output logic                      illegal
);
    localparam int NREG = 2**REG_SEL_W;
    localparam int IR_W = 3 + 2*REG_SEL_W;

    localparam logic [1:0] T0 = 2'd0;
    localparam logic [1:0] T1 = 2'd1;
    localparam logic [1:0] T2 = 2'd2;
    localparam logic [1:0] T3 = 2'd3;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
`ifdef PROC_CTRL_MVNZ_EN
    localparam logic [2:0] OP_MVNZ = 3'b100;
`endif

    logic [1:0]           state_q, state_d;
    logic [IR_W-1:0]      ir_q, ir_d;
    logic [2:0]           op;
    logic [REG_SEL_W-1:0] x, y;

    assign op = ir_q[IR_W-1 -: 3];
    assign x  = ir_q[2*REG_SEL_W-1 -: REG_SEL_W];
    assign y  = ir_q[REG_SEL_W-1:0];

    // Only the low IR_W bits of din form the instruction; data in T1 goes straight to the bus.
    generate
        if (DATA_WIDTH > IR_W) begin : g_din_unused
            logic unused_din;
            assign unused_din = ^din[DATA_WIDTH-1:IR_W];
        end
    endgenerate
`ifndef PROC_CTRL_MVNZ_EN
    logic unused_g_zero;
    assign unused_g_zero = g_zero;
`endif

    function automatic logic [NREG-1:0] sel1h(input logic [REG_SEL_W-1:0] s);
        sel1h    = '0;
        sel1h[s] = 1'b1;
    endfunction

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= T0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        irin    = 1'b0;
        rin     = '0;
        rout    = '0;
        gout    = 1'b0;
        dinout  = 1'b0;
        ain     = 1'b0;
        gin     = 1'b0;
        sub     = 1'b0;
        done    = 1'b0;
        illegal = 1'b0;
        case (state_q)
            T0: begin
                irin = run;
                if (run) begin
                    ir_d    = din[IR_W-1:0];
                    state_d = T1;
                end
            end
            T1: begin
                case (op)
                    OP_MV: begin
                        rout    = sel1h(y);
                        rin     = sel1h(x);
                        done    = 1'b1;
                        state_d = T0;
                    end
                    OP_MVI: begin
                        dinout  = 1'b1;
                        rin     = sel1h(x);
                        done    = 1'b1;
                        state_d = T0;
                    end
                    OP_ADD, OP_SUB: begin
                        rout    = sel1h(x);
                        ain     = 1'b1;
                        state_d = T2;
                    end
`ifdef PROC_CTRL_MVNZ_EN
                    OP_MVNZ: begin
                        if (!g_zero) begin
                            rout = sel1h(y);
                            rin  = sel1h(x);
                        end
                        done    = 1'b1;
                        state_d = T0;
                    end
`endif
                    default: begin
                        illegal = 1'b1;
                        done    = 1'b1;
                        state_d = T0;
                    end
                endcase
            end
            T2: begin
                rout    = sel1h(y);
                gin     = 1'b1;
                sub     = (op == OP_SUB);
                state_d = T3;
            end
            // sub stays asserted through write-back so the ALU mode is stable; G is not reloaded.
            T3: begin
                gout    = 1'b1;
                rin     = sel1h(x);
                sub     = (op == OP_SUB);
                done    = 1'b1;
                state_d = T0;
            end
            default: state_d = T0;
        endcase
    end
endmodule
